// File: rtl/ssd_pkg.sv
// Shared constants for the 7-segment display blocks: active-low glyph
// patterns (a..g, dp) and the all-digits-off select value.
package ssd_pkg;

    localparam logic [7:0] SS_0  = 8'b00000011;
    localparam logic [7:0] SS_1  = 8'b10011111;
    localparam logic [7:0] SS_2  = 8'b00100101;
    localparam logic [7:0] SS_3  = 8'b00001101;
    localparam logic [7:0] SS_4  = 8'b10011001;
    localparam logic [7:0] SS_5  = 8'b01001001;
    localparam logic [7:0] SS_6  = 8'b01000001;
    localparam logic [7:0] SS_7  = 8'b00011111;
    localparam logic [7:0] SS_8  = 8'b00000001;
    localparam logic [7:0] SS_9  = 8'b00001001;
    localparam logic [7:0] SS_10 = 8'b00010001;
    localparam logic [7:0] SS_11 = 8'b11000001;
    localparam logic [7:0] SS_12 = 8'b01100011;
    localparam logic [7:0] SS_13 = 8'b10000101;
    localparam logic [7:0] SS_14 = 8'b01100001;
    localparam logic [7:0] SS_15 = 8'b01110001;

    localparam logic [7:0] SS_TAB [16] = '{SS_0, SS_1, SS_2, SS_3, SS_4, SS_5, SS_6, SS_7,
                                           SS_8, SS_9, SS_10, SS_11, SS_12, SS_13, SS_14, SS_15};

    localparam logic [3:0] SSD_BLANK = 4'b1111;

endpackage

// File: rtl/ssd_scan_monitor_if.sv
// Scanned display bus: active-low segments plus active-low digit select.
interface ssd_scan_monitor_if;
    logic [7:0] seg;
    logic [3:0] ssd_ctl;

    modport master (output seg, output ssd_ctl);
    modport slave  (input seg, input ssd_ctl);
endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational reverse lookup of a 7-segment pattern (a..g, dp excluded)
// to its hex value; match is low when the pattern is not a known glyph.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       match
);

    // Pattern-to-nibble lookup
    always_comb begin
        value = 4'h0;
        match = 1'b1;
        case (pattern)
            SS_0[7:1]:  value = 4'h0;
            SS_1[7:1]:  value = 4'h1;
            SS_2[7:1]:  value = 4'h2;
            SS_3[7:1]:  value = 4'h3;
            SS_4[7:1]:  value = 4'h4;
            SS_5[7:1]:  value = 4'h5;
            SS_6[7:1]:  value = 4'h6;
            SS_7[7:1]:  value = 4'h7;
            SS_8[7:1]:  value = 4'h8;
            SS_9[7:1]:  value = 4'h9;
            SS_10[7:1]: value = 4'hA;
            SS_11[7:1]: value = 4'hB;
            SS_12[7:1]: value = 4'hC;
            SS_13[7:1]: value = 4'hD;
            SS_14[7:1]: value = 4'hE;
            SS_15[7:1]: value = 4'hF;
            default:    match = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_monitor.sv
// Watches a scanned 7-segment bus, commits each {ssd_ctl,seg} value once it has
// been stable for STABLE_CYCLES edges, and decodes it back into per-digit nibbles.
module ssd_scan_monitor
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
)(
    input  logic                 CLK_temp,
    input  logic                 rst_n,
    ssd_scan_monitor_if.slave    bus,
    input  logic                 clr_err,
    output logic [15:0]          digits,
    output logic [3:0]           digit_valid,
    output logic [3:0]           dp,
    output logic                 frame_done,
    output logic [3:0]           last_bin,
    output logic                 err_pattern,
    output logic                 err_ctl
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [11:0]      s_q_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [3:0]       seen_r, seen_nxt_s, seen_tmp_s;
    logic [11:0]      sample_s;
    logic             changed_s, commit_s;
    logic [3:0]       glyph_val_s;
    logic             glyph_hit_s;
    logic [1:0]       sel_idx_s;
    logic             sel_one_s, sel_bad_s;
    logic [15:0]      digits_nxt_s;
    logic [3:0]       valid_nxt_s, dp_nxt_s, last_bin_nxt_s;
    logic             frame_done_nxt_s, err_pattern_nxt_s, err_ctl_nxt_s;

    assign sample_s  = {bus.ssd_ctl, bus.seg};
    assign changed_s = (sample_s != s_q_r);

    ssd_glyph_decode u_decode (
        .pattern (sample_s[7:1]),
        .value   (glyph_val_s),
        .match   (glyph_hit_s)
    );

    // Stability counter next state; a fresh value only commits at once when one edge suffices
    always_comb begin
        cnt_nxt_s = cnt_r;
        commit_s  = 1'b0;
        if (changed_s) begin
            cnt_nxt_s = CNT_W'(1);
            commit_s  = (STABLE_C == CNT_W'(1));
        end else if (cnt_r < STABLE_C) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            commit_s  = (cnt_r == STABLE_C - CNT_W'(1));
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Digit-select classification of the value being committed
    always_comb begin
        sel_idx_s = 2'd0;
        sel_one_s = 1'b0;
        sel_bad_s = 1'b0;
        case (sample_s[11:8])
            4'b1110:   begin sel_idx_s = 2'd0; sel_one_s = 1'b1; end
            4'b1101:   begin sel_idx_s = 2'd1; sel_one_s = 1'b1; end
            4'b1011:   begin sel_idx_s = 2'd2; sel_one_s = 1'b1; end
            4'b0111:   begin sel_idx_s = 2'd3; sel_one_s = 1'b1; end
            SSD_BLANK: sel_bad_s = 1'b0;
            default:   sel_bad_s = 1'b1;
        endcase
    end

    // Commit actions; a newly raised error overrides a simultaneous clear
    always_comb begin
        digits_nxt_s      = digits;
        valid_nxt_s       = digit_valid;
        dp_nxt_s          = dp;
        last_bin_nxt_s    = last_bin;
        seen_nxt_s        = seen_r;
        seen_tmp_s        = seen_r;
        frame_done_nxt_s  = 1'b0;
        err_pattern_nxt_s = clr_err ? 1'b0 : err_pattern;
        err_ctl_nxt_s     = clr_err ? 1'b0 : err_ctl;
        if (commit_s && sel_one_s) begin
            if (glyph_hit_s) begin
                digits_nxt_s[{sel_idx_s, 2'b00} +: 4] = glyph_val_s;
                valid_nxt_s[sel_idx_s]                = 1'b1;
                dp_nxt_s[sel_idx_s]                   = ~sample_s[0];
                last_bin_nxt_s                        = glyph_val_s;
                seen_tmp_s                            = seen_r | (4'b0001 << sel_idx_s);
                if (seen_tmp_s == 4'b1111) begin
                    frame_done_nxt_s = 1'b1;
                    seen_nxt_s       = 4'b0000;
                end else begin
                    seen_nxt_s = seen_tmp_s;
                end
            end else begin
                valid_nxt_s[sel_idx_s] = 1'b0;
                err_pattern_nxt_s      = 1'b1;
            end
        end else if (commit_s && sel_bad_s) begin
            err_ctl_nxt_s = 1'b1;
        end else begin
            frame_done_nxt_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK_temp or negedge rst_n) begin
        if (!rst_n) begin
            s_q_r       <= 12'hFFF;
            cnt_r       <= STABLE_C;
            seen_r      <= 4'b0000;
            digits      <= 16'h0000;
            digit_valid <= 4'b0000;
            dp          <= 4'b0000;
            frame_done  <= 1'b0;
            last_bin    <= 4'h0;
            err_pattern <= 1'b0;
            err_ctl     <= 1'b0;
        end else begin
            s_q_r       <= sample_s;
            cnt_r       <= cnt_nxt_s;
            seen_r      <= seen_nxt_s;
            digits      <= digits_nxt_s;
            digit_valid <= valid_nxt_s;
            dp          <= dp_nxt_s;
            frame_done  <= frame_done_nxt_s;
            last_bin    <= last_bin_nxt_s;
            err_pattern <= err_pattern_nxt_s;
            err_ctl     <= err_ctl_nxt_s;
        end
    end

endmodule

// File: tb/tb_ssd_scan_monitor.sv
// Directed bench for ssd_scan_monitor with STABLE_CYCLES=4: commit timing,
// glitch rejection, frame pulse, error flags, countdown and mid-hold reset.
module tb_ssd_scan_monitor;
    import ssd_pkg::*;

    logic        CLK_temp = 1'b0;
    logic        rst_n;
    logic        clr_err;
    logic [15:0] digits;
    logic [3:0]  digit_valid, dp, last_bin;
    logic        frame_done, err_pattern, err_ctl;
    int          tests_run = 0;
    int          tests_failed = 0;

    ssd_scan_monitor_if bus_if ();

    ssd_scan_monitor #(.STABLE_CYCLES(4)) dut (
        .CLK_temp    (CLK_temp),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .clr_err     (clr_err),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp          (dp),
        .frame_done  (frame_done),
        .last_bin    (last_bin),
        .err_pattern (err_pattern),
        .err_ctl     (err_ctl)
    );

    always #5 CLK_temp = ~CLK_temp;

    task automatic step(input int n);
        repeat (n) @(posedge CLK_temp);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [7:0] s);
        bus_if.ssd_ctl = ctl;
        bus_if.seg     = s;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr_err = 1'b0;
        drive(4'b1111, 8'hFF);
        step(2);
        tests_run++;
        if ({digits, digit_valid, dp, frame_done, last_bin, err_pattern, err_ctl} !== 34'd0) begin
            $display("FAIL reset_outputs: got digits=%h valid=%b dp=%b fd=%b lb=%h ep=%b ec=%b, expected all 0",
                     digits, digit_valid, dp, frame_done, last_bin, err_pattern, err_ctl);
            tests_failed++;
        end
        rst_n = 1'b1;
        step(2);
        tests_run++;
        if (digit_valid !== 4'b0000) begin
            $display("FAIL reset_idle_bus: got valid=%b expected 0000", digit_valid);
            tests_failed++;
        end
    endtask

    task automatic test_first_commit;
        drive(4'b1110, 8'b00001101);
        step(3);
        tests_run++;
        if (digit_valid !== 4'b0000 || digits !== 16'h0000) begin
            $display("FAIL t1_early: got valid=%b digits=%h expected 0000/0000", digit_valid, digits);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (digits !== 16'h0003 || digit_valid !== 4'b0001 || last_bin !== 4'h3) begin
            $display("FAIL t1_commit: got digits=%h valid=%b lb=%h expected 0003/0001/3", digits, digit_valid, last_bin);
            tests_failed++;
        end
    endtask

    task automatic test_glitch;
        drive(4'b1101, SS_7);
        step(3);
        drive(4'b1101, SS_8);
        step(3);
        tests_run++;
        if (digits[7:4] !== 4'h0 || digit_valid[1] !== 1'b0 || last_bin !== 4'h3) begin
            $display("FAIL t2_glitch: got d1=%h v1=%b lb=%h expected 0/0/3", digits[7:4], digit_valid[1], last_bin);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (digits !== 16'h0083 || last_bin !== 4'h8 || digit_valid !== 4'b0011) begin
            $display("FAIL t2_commit: got digits=%h lb=%h valid=%b expected 0083/8/0011", digits, last_bin, digit_valid);
            tests_failed++;
        end
    endtask

    task automatic test_frame;
        logic [7:0] pat [4];
        pat[0] = SS_15; pat[1] = SS_14; pat[2] = SS_13 & 8'hFE; pat[3] = SS_12;
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), pat[d]);
            step(4);
            tests_run++;
            if (frame_done !== (d == 3)) begin
                $display("FAIL t3_frame_done_d%0d: got %b expected %b", d, frame_done, (d == 3));
                tests_failed++;
            end
        end
        tests_run++;
        if (digits !== 16'hCDEF || dp !== 4'b0100 || digit_valid !== 4'b1111) begin
            $display("FAIL t3_frame: got digits=%h dp=%b valid=%b expected CDEF/0100/1111", digits, dp, digit_valid);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (frame_done !== 1'b0) begin
            $display("FAIL t3_pulse_width: got %b expected 0", frame_done);
            tests_failed++;
        end
    endtask

    task automatic test_errors;
        drive(4'b1101, 8'b11111110);
        step(4);
        tests_run++;
        if (err_pattern !== 1'b1 || err_ctl !== 1'b0 || digit_valid !== 4'b1101 || digits[7:4] !== 4'hE) begin
            $display("FAIL t4_pattern: got ep=%b ec=%b valid=%b d1=%h expected 1/0/1101/E",
                     err_pattern, err_ctl, digit_valid, digits[7:4]);
            tests_failed++;
        end
        drive(4'b1100, 8'b11111110);
        step(3);
        tests_run++;
        if (err_ctl !== 1'b0) begin
            $display("FAIL t4_ctl_early: got %b expected 0", err_ctl);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (err_ctl !== 1'b1 || digits !== 16'hCDEF) begin
            $display("FAIL t4_ctl: got ec=%b digits=%h expected 1/CDEF", err_ctl, digits);
            tests_failed++;
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        tests_run++;
        if (err_pattern !== 1'b0 || err_ctl !== 1'b0) begin
            $display("FAIL t4_clear: got ep=%b ec=%b expected 0/0", err_pattern, err_ctl);
            tests_failed++;
        end
        drive(4'b1100, 8'h00);
        step(3);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        tests_run++;
        if (err_ctl !== 1'b1) begin
            $display("FAIL t4_set_wins: got %b expected 1", err_ctl);
            tests_failed++;
        end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        tests_run++;
        if (err_ctl !== 1'b0) begin
            $display("FAIL t4_reclear: got %b expected 0", err_ctl);
            tests_failed++;
        end
    endtask

    task automatic test_countdown;
        int v;
        for (int i = 0; i <= 16; i++) begin
            v = (i == 16) ? 15 : 15 - i;
            drive(4'b1110, SS_TAB[v]);
            step(4);
            tests_run++;
            if (last_bin !== 4'(v) || digits[3:0] !== 4'(v) || err_pattern !== 1'b0 || err_ctl !== 1'b0) begin
                $display("FAIL t5_count_%0d: got lb=%h d0=%h ep=%b ec=%b expected %h/%h/0/0",
                         i, last_bin, digits[3:0], err_pattern, err_ctl, 4'(v), 4'(v));
                tests_failed++;
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        drive(4'b1110, SS_5);
        step(2);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({digits, digit_valid, dp, frame_done, last_bin, err_pattern, err_ctl} !== 34'd0) begin
            $display("FAIL t6_in_reset: got digits=%h valid=%b dp=%b lb=%h expected all 0", digits, digit_valid, dp, last_bin);
            tests_failed++;
        end
        step(1);
        rst_n = 1'b1;
        step(3);
        tests_run++;
        if (digit_valid !== 4'b0000 || last_bin !== 4'h0) begin
            $display("FAIL t6_early: got valid=%b lb=%h expected 0000/0", digit_valid, last_bin);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (digits !== 16'h0005 || digit_valid !== 4'b0001 || last_bin !== 4'h5) begin
            $display("FAIL t6_commit: got digits=%h valid=%b lb=%h expected 0005/0001/5", digits, digit_valid, last_bin);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_first_commit();
        test_glitch();
        test_frame();
        test_errors();
        test_countdown();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
